// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control unit for the 16-bit RISC core. It sequences each
// instruction through FETCH -> DECODE -> EXEC -> MEM -> WB and drives the
// ALU_CTRL / operand selects of ALU_16bits together with the IR, PC, branch
// target, memory, flag-register and register-file enables.
//
// Only the state is registered. Every strobe is decoded combinationally from
// the current state, the IR opcode, the registered flags and mem_ack, so the
// datapath sees the strobes in the same cycle the condition becomes true.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (forces RST, all strobes low)
//   instr      current IR contents, opcode = instr[15:12]
//   nzvc_q     registered flags {N,Z,V,C}
//   mem_ack    one-cycle memory completion pulse
//   ir_we      load IR from memory data
//   pc_we      load PC
//   pc_src     PC source: 0=ALU result, 1=branch target reg, 2=R[rs]
//   tgt_we     load branch target reg from ALU result
//   mem_req    memory request, held until mem_ack
//   mem_we     write qualifier for mem_req
//   addr_src   memory address: 0=PC, 1=R[rs]
//   alu_ctrl   ALU_CTRL: 0=A+B, 1=two's complement of B
//   alu_a_sel  ALU A operand: 0=R[rs], 1=PC
//   alu_b_sel  ALU B operand: 0=R[rt], 1=constant 1, 2=sext(instr[7:0])
//   flags_we   load nzvc_q from the ALU flags
//   reg_we     register-file write of R[rd]
//   reg_wsel   write-back source: 0=ALUOut, 1=MDR
//   illegal    one-cycle pulse in EXEC for an undefined opcode
//   halted     high while in HALT
//   state      current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int OPC_W = 4,
    parameter int OFF_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic [3:0]  nzvc_q,
    input  logic        mem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        tgt_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        alu_ctrl,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        flags_we,
    output logic        reg_we,
    output logic        reg_wsel,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_RST    = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_BZ   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_BN   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT = {OPC_W{1'b1}};

    // Operand select / source encodings shared with the datapath.
    localparam logic [1:0] PC_SRC_ALU = 2'd0;
    localparam logic [1:0] PC_SRC_TGT = 2'd1;
    localparam logic [1:0] PC_SRC_RS  = 2'd2;
    localparam logic [1:0] B_SEL_RT   = 2'd0;
    localparam logic [1:0] B_SEL_ONE  = 2'd1;
    localparam logic [1:0] B_SEL_OFF  = 2'd2;

    state_t           state_q;
    logic [OPC_W-1:0] op;

    assign op    = instr[15 -: OPC_W];
    assign state = state_q;

    // The register fields and the branch offset are consumed by the datapath,
    // and the V/C flags are not used by any branch; none of them steer control.
    logic unused_bits;
    assign unused_bits = ^{instr[15-OPC_W:OFF_W], instr[OFF_W-1:0], nzvc_q[1:0]};

    function automatic logic op_is_legal(input logic [OPC_W-1:0] o);
        case (o)
            OP_ADD, OP_NEG, OP_LD, OP_ST,
            OP_BZ, OP_BN, OP_JMP, OP_HALT: op_is_legal = 1'b1;
            default:                       op_is_legal = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            case (state_q)
                S_RST:    state_q <= S_FETCH;
                S_FETCH:  if (mem_ack) state_q <= S_DECODE;
                S_DECODE: state_q <= (op == OP_HALT) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    case (op)
                        OP_ADD, OP_NEG: state_q <= S_WB;
                        OP_LD, OP_ST:   state_q <= S_MEM;
                        // Branches, JMP and illegal opcodes retire here.
                        default:        state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) state_q <= (op == OP_LD) ? S_WB : S_FETCH;
                end
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_RST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_ALU;
        tgt_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_src  = 1'b0;
        alu_ctrl  = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = B_SEL_RT;
        flags_we  = 1'b0;
        reg_we    = 1'b0;
        reg_wsel  = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                // IR capture and PC+1 happen together on the ack cycle;
                // the increment goes through the ALU but never the flags.
                if (mem_ack) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    pc_src    = PC_SRC_ALU;
                    alu_a_sel = 1'b1;
                    alu_b_sel = B_SEL_ONE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively for every opcode.
                alu_a_sel = 1'b1;
                alu_b_sel = B_SEL_OFF;
                tgt_we    = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD: flags_we = 1'b1;
                    OP_NEG: begin
                        alu_ctrl = 1'b1;
                        flags_we = 1'b1;
                    end
                    OP_BZ: begin
                        pc_we  = nzvc_q[2];
                        pc_src = PC_SRC_TGT;
                    end
                    OP_BN: begin
                        pc_we  = nzvc_q[3];
                        pc_src = PC_SRC_TGT;
                    end
                    OP_JMP: begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_RS;
                    end
                    default: illegal = !op_is_legal(op);
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = (op == OP_ST);
            end
            S_WB: begin
                reg_we   = 1'b1;
                reg_wsel = (op == OP_LD);
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each step applies inputs shortly after a
// rising edge, then compares the state code and the whole strobe bundle against
// hand-computed values before the next edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [3:0]  nzvc_q;
    logic        mem_ack;
    logic        ir_we, pc_we, tgt_we, mem_req, mem_we, addr_src;
    logic        alu_ctrl, alu_a_sel, flags_we, reg_we, reg_wsel;
    logic        illegal, halted;
    logic [1:0]  pc_src, alu_b_sel;
    logic [2:0]  state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    multicycle_ctrl #(.OPC_W(4), .OFF_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .nzvc_q    (nzvc_q),
        .mem_ack   (mem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .tgt_we    (tgt_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_src  (addr_src),
        .alu_ctrl  (alu_ctrl),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .flags_we  (flags_we),
        .reg_we    (reg_we),
        .reg_wsel  (reg_wsel),
        .illegal   (illegal),
        .halted    (halted),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bundle layout, MSB first.
    localparam logic [16:0] O_IR    = 17'd1 << 16;
    localparam logic [16:0] O_PCWE  = 17'd1 << 15;
    localparam logic [16:0] O_PCTGT = 17'd1 << 13;  // pc_src = 1
    localparam logic [16:0] O_PCRS  = 17'd2 << 13;  // pc_src = 2
    localparam logic [16:0] O_TGT   = 17'd1 << 12;
    localparam logic [16:0] O_MREQ  = 17'd1 << 11;
    localparam logic [16:0] O_MWE   = 17'd1 << 10;
    localparam logic [16:0] O_ADDR  = 17'd1 << 9;
    localparam logic [16:0] O_ACTRL = 17'd1 << 8;
    localparam logic [16:0] O_APC   = 17'd1 << 7;
    localparam logic [16:0] O_BONE  = 17'd1 << 5;   // alu_b_sel = 1
    localparam logic [16:0] O_BOFF  = 17'd2 << 5;   // alu_b_sel = 2
    localparam logic [16:0] O_FWE   = 17'd1 << 4;
    localparam logic [16:0] O_RWE   = 17'd1 << 3;
    localparam logic [16:0] O_RWSEL = 17'd1 << 2;
    localparam logic [16:0] O_ILL   = 17'd1 << 1;
    localparam logic [16:0] O_HALT  = 17'd1;
    localparam logic [16:0] O_NONE  = 17'd0;

    localparam logic [16:0] O_FETCH_ACK = O_IR | O_PCWE | O_MREQ | O_APC | O_BONE;
    localparam logic [16:0] O_DECODE    = O_TGT | O_APC | O_BOFF;

    logic [16:0] outs;
    assign outs = {ir_we, pc_we, pc_src, tgt_we, mem_req, mem_we, addr_src,
                   alu_ctrl, alu_a_sel, alu_b_sel, flags_we, reg_we, reg_wsel,
                   illegal, halted};

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] exp_st, input logic [16:0] exp_o);
        #1;
        chk({tag, ".state"}, {14'd0, state}, {14'd0, exp_st});
        chk({tag, ".outs"}, outs, exp_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        instr   = 16'h0000;
        nzvc_q  = 4'b0000;
        mem_ack = 1'b0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("por.state", {14'd0, state}, 17'd6);
        chk("por.outs", outs, O_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FETCH waits without ack
        cyc("fetch_wait0", 3'd0, O_MREQ);
        cyc("fetch_wait1", 3'd0, O_MREQ);

        // Reset in the middle of a pending fetch drops mem_req at once
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.state", {14'd0, state}, 17'd6);
        chk("midrst.outs", outs, O_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_hold.state", {14'd0, state}, 17'd6);
        @(posedge clk);
        #1;

        // ADD: 0,1,2,4 then FETCH; ack held high through DECODE is ignored
        instr = 16'h0123; mem_ack = 1'b1;
        cyc("add_fetch", 3'd0, O_FETCH_ACK);
        cyc("add_dec", 3'd1, O_DECODE);
        mem_ack = 1'b0;
        cyc("add_exec", 3'd2, O_FWE);
        cyc("add_wb", 3'd4, O_RWE);

        // NEG
        instr = 16'h1205; mem_ack = 1'b1;
        cyc("neg_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("neg_dec", 3'd1, O_DECODE);
        cyc("neg_exec", 3'd2, O_ACTRL | O_FWE);
        cyc("neg_wb", 3'd4, O_RWE);

        // LD with ack on the fourth MEM cycle: 8 cycles total
        instr = 16'h2340; mem_ack = 1'b1;
        cyc("ld_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("ld_dec", 3'd1, O_DECODE);
        cyc("ld_exec", 3'd2, O_NONE);
        cyc("ld_mem0", 3'd3, O_MREQ | O_ADDR);
        cyc("ld_mem1", 3'd3, O_MREQ | O_ADDR);
        cyc("ld_mem2", 3'd3, O_MREQ | O_ADDR);
        mem_ack = 1'b1;
        cyc("ld_mem3", 3'd3, O_MREQ | O_ADDR);
        mem_ack = 1'b0;
        cyc("ld_wb", 3'd4, O_RWE | O_RWSEL);

        // ST with zero-wait memory, back to FETCH after MEM
        instr = 16'h3340; mem_ack = 1'b1;
        cyc("st_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("st_dec", 3'd1, O_DECODE);
        cyc("st_exec", 3'd2, O_NONE);
        mem_ack = 1'b1;
        cyc("st_mem", 3'd3, O_MREQ | O_MWE | O_ADDR);

        // BZ taken (Z=1)
        instr = 16'h40FE; nzvc_q = 4'b0100;
        cyc("bz_t_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("bz_t_dec", 3'd1, O_DECODE);
        cyc("bz_t_exec", 3'd2, O_PCWE | O_PCTGT);

        // BZ not taken (Z=0)
        nzvc_q = 4'b0000; mem_ack = 1'b1;
        cyc("bz_n_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("bz_n_dec", 3'd1, O_DECODE);
        cyc("bz_n_exec", 3'd2, O_PCTGT);

        // BN taken on N, not taken on Z alone
        instr = 16'h5010; nzvc_q = 4'b1000; mem_ack = 1'b1;
        cyc("bn_t_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("bn_t_dec", 3'd1, O_DECODE);
        cyc("bn_t_exec", 3'd2, O_PCWE | O_PCTGT);
        nzvc_q = 4'b0100; mem_ack = 1'b1;
        cyc("bn_n_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("bn_n_dec", 3'd1, O_DECODE);
        cyc("bn_n_exec", 3'd2, O_PCTGT);

        // JMP
        instr = 16'h6300; nzvc_q = 4'b0000; mem_ack = 1'b1;
        cyc("jmp_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("jmp_dec", 3'd1, O_DECODE);
        cyc("jmp_exec", 3'd2, O_PCWE | O_PCRS);

        // Illegal opcodes 9 and E: single-cycle pulse, then FETCH
        instr = 16'h9000; mem_ack = 1'b1;
        cyc("ill9_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("ill9_dec", 3'd1, O_DECODE);
        cyc("ill9_exec", 3'd2, O_ILL);
        cyc("ill9_after", 3'd0, O_MREQ);
        instr = 16'hE000; mem_ack = 1'b1;
        cyc("illE_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("illE_dec", 3'd1, O_DECODE);
        cyc("illE_exec", 3'd2, O_ILL);

        // HALT absorbs for 20 cycles with mem_ack toggling
        instr = 16'hF000; mem_ack = 1'b1;
        cyc("halt_fetch", 3'd0, O_FETCH_ACK);
        mem_ack = 1'b0;
        cyc("halt_dec", 3'd1, O_DECODE);
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0];
            cyc("halt_hold", 3'd5, O_HALT);
        end

        // Only reset leaves HALT
        mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("halt_rst.state", {14'd0, state}, 17'd6);
        chk("halt_rst.outs", outs, O_NONE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish within 20000");
        $fatal(1, "timeout");
    end

endmodule
